// File: rtl/arrow_field.sv
`default_nettype none
// ============================================================================
// Module   : arrow_field
// Purpose  : Falling-arrow sprite pool with hit/miss resolution and a
//            fixed two-cycle pixel render pipeline for the video mixer.
// Revision : 1.0
// ============================================================================
module arrow_field #(
    parameter int NUM_SLOTS  = 8,
    parameter int NUM_LANES  = 4,
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 32,
    parameter int LANE_X0    = 256,
    parameter int LANE_PITCH = 128,
    parameter int HIT_Y      = 640,
    parameter int HIT_TOL    = 24,
    parameter int MISS_Y     = 720,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int CW = $clog2(NUM_SLOTS + 1)
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [10:0]   hcount_in,
    input  logic [9:0]    vcount_in,
    input  logic          spawn_valid_in,
    input  logic [LW-1:0] spawn_lane_in,
    input  logic [2:0]    spawn_speed_in,
    input  logic          hit_valid_in,
    input  logic [LW-1:0] hit_lane_in,
    output logic          spawn_drop_out,
    output logic          hit_out,
    output logic          miss_out,
    output logic [CW-1:0] active_count_out,
    output logic [11:0]   pixel_out,
    output logic          valid_out
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [10:0] c_hit_lo = 11'(HIT_Y - HIT_TOL);
    localparam logic [10:0] c_hit_hi = 11'(HIT_Y + HIT_TOL);
    localparam logic [10:0] c_miss_y = 11'(MISS_Y);

    logic [NUM_SLOTS-1:0] r_active;
    logic [LW-1:0]        r_lane  [NUM_SLOTS];
    logic [2:0]           r_speed [NUM_SLOTS];
    logic [9:0]           r_y     [NUM_SLOTS];

    logic                 w_tick;
    logic                 w_lane_ok;
    logic                 w_hit_found;
    logic [SW-1:0]        w_hit_idx;
    logic [9:0]           w_hit_y;
    logic                 w_hit_fire;
    logic                 w_free_found;
    logic [SW-1:0]        w_free_idx;
    logic                 w_spawn_fire;
    logic [NUM_SLOTS-1:0] w_nxt_active;
    logic [9:0]           w_nxt_y [NUM_SLOTS];
    logic [10:0]          w_sum   [NUM_SLOTS];
    logic                 w_any_miss;
    logic [CW-1:0]        w_nxt_count;
    logic [2:0]           w_speed_eff;

    assign w_tick       = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign w_lane_ok    = (32'(spawn_lane_in) < NUM_LANES);
    assign w_hit_fire   = hit_valid_in && w_hit_found;
    assign w_spawn_fire = spawn_valid_in && w_lane_ok && w_free_found;
    assign w_speed_eff  = (spawn_speed_in == 3'd0) ? 3'd1 : spawn_speed_in;

    // Strict '>' keeps the lowest index on equal y.
    always_comb begin
        w_hit_found = 1'b0;
        w_hit_idx   = '0;
        w_hit_y     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_active[i] && (r_lane[i] == hit_lane_in) &&
                ({1'b0, r_y[i]} >= c_hit_lo) && ({1'b0, r_y[i]} <= c_hit_hi) &&
                (!w_hit_found || (r_y[i] > w_hit_y))) begin
                w_hit_found = 1'b1;
                w_hit_idx   = SW'(i);
                w_hit_y     = r_y[i];
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(i);
            end
        end
    end

    // Hit takes precedence over advance; spawn only lands in a slot that was
    // already free, so it never collides with a hit or advance of that slot.
    always_comb begin
        w_any_miss  = 1'b0;
        w_nxt_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_sum[i]        = {1'b0, r_y[i]} + 11'(r_speed[i]);
            w_nxt_active[i] = r_active[i];
            w_nxt_y[i]      = r_y[i];
            if (w_hit_fire && (w_hit_idx == SW'(i))) begin
                w_nxt_active[i] = 1'b0;
            end else if (w_tick && r_active[i]) begin
                if (w_sum[i] >= c_miss_y) begin
                    w_nxt_active[i] = 1'b0;
                    w_any_miss      = 1'b1;
                end else begin
                    w_nxt_y[i] = w_sum[i][9:0];
                end
            end
            if (w_spawn_fire && (w_free_idx == SW'(i))) begin
                w_nxt_active[i] = 1'b1;
                w_nxt_y[i]      = '0;
            end
            w_nxt_count = w_nxt_count + CW'(w_nxt_active[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_active         <= '0;
            spawn_drop_out   <= 1'b0;
            hit_out          <= 1'b0;
            miss_out         <= 1'b0;
            active_count_out <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_lane[i]  <= '0;
                r_speed[i] <= '0;
                r_y[i]     <= '0;
            end
        end else begin
            r_active         <= w_nxt_active;
            spawn_drop_out   <= spawn_valid_in && w_lane_ok && !w_free_found;
            hit_out          <= w_hit_fire;
            miss_out         <= w_any_miss;
            active_count_out <= w_nxt_count;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_y[i] <= w_nxt_y[i];
                if (w_spawn_fire && (w_free_idx == SW'(i))) begin
                    r_lane[i]  <= spawn_lane_in;
                    r_speed[i] <= w_speed_eff;
                end
            end
        end
    end

    // Render stage 1: per-slot coverage, with the lane captured alongside so
    // stage 2 is immune to the slot being reused in between.
    logic [NUM_SLOTS-1:0] w_cov;
    logic [NUM_SLOTS-1:0] r_cov;
    logic [LW-1:0]        r_cov_lane [NUM_SLOTS];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic [10:0] w_xl;
        logic [10:0] w_xr;
        logic [10:0] w_yt;
        logic [10:0] w_yb;
        assign w_xl = 11'(LANE_X0 + int'(r_lane[gi]) * LANE_PITCH);
        assign w_xr = w_xl + 11'(WIDTH - 1);
        assign w_yt = {1'b0, r_y[gi]};
        assign w_yb = w_yt + 11'(HEIGHT - 1);
        assign w_cov[gi] = r_active[gi] &&
                           (hcount_in >= w_xl) && (hcount_in <= w_xr) &&
                           ({1'b0, vcount_in} >= w_yt) && ({1'b0, vcount_in} <= w_yb);
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_cov <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_cov_lane[i] <= '0;
            end
        end else begin
            r_cov <= w_cov;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_cov_lane[i] <= r_lane[i];
            end
        end
    end

    // Render stage 2: lowest covering index selects the colour.
    logic          w_sel_found;
    logic [LW-1:0] w_sel_lane;
    logic [11:0]   w_colour;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_lane  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_cov[i]) begin
                w_sel_found = 1'b1;
                w_sel_lane  = r_cov_lane[i];
            end
        end
    end

    always_comb begin
        w_colour = 12'h000;
        case (2'(w_sel_lane))
            2'd0:    w_colour = 12'hF00;
            2'd1:    w_colour = 12'h0F0;
            2'd2:    w_colour = 12'h00F;
            default: w_colour = 12'hFF0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            pixel_out <= 12'h000;
            valid_out <= 1'b0;
        end else begin
            pixel_out <= w_sel_found ? w_colour : 12'h000;
            valid_out <= w_sel_found;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arrow_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_arrow_field
// Purpose  : Self-checking bench for arrow_field; pixel expectations go
//            through a due-cycle scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_arrow_field;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        spawn_valid_in;
    logic [1:0]  spawn_lane_in;
    logic [2:0]  spawn_speed_in;
    logic        hit_valid_in;
    logic [1:0]  hit_lane_in;
    logic        spawn_drop_out;
    logic        hit_out;
    logic        miss_out;
    logic [3:0]  active_count_out;
    logic [11:0] pixel_out;
    logic        valid_out;

    // Second instance with a 3-bit lane port so an out-of-range lane exists.
    logic        s5_valid;
    logic [2:0]  s5_lane;
    logic [2:0]  h5_lane;
    logic        d5_drop;
    logic        d5_hit;
    logic        d5_miss;
    logic [1:0]  d5_count;
    logic [11:0] d5_pixel;
    logic        d5_valid;

    arrow_field dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .spawn_valid_in   (spawn_valid_in),
        .spawn_lane_in    (spawn_lane_in),
        .spawn_speed_in   (spawn_speed_in),
        .hit_valid_in     (hit_valid_in),
        .hit_lane_in      (hit_lane_in),
        .spawn_drop_out   (spawn_drop_out),
        .hit_out          (hit_out),
        .miss_out         (miss_out),
        .active_count_out (active_count_out),
        .pixel_out        (pixel_out),
        .valid_out        (valid_out)
    );

    arrow_field #(.NUM_SLOTS(2), .NUM_LANES(5)) dut5 (
        .clk              (clk),
        .rst_in           (rst_in),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .spawn_valid_in   (s5_valid),
        .spawn_lane_in    (s5_lane),
        .spawn_speed_in   (spawn_speed_in),
        .hit_valid_in     (1'b0),
        .hit_lane_in      (h5_lane),
        .spawn_drop_out   (d5_drop),
        .hit_out          (d5_hit),
        .miss_out         (d5_miss),
        .active_count_out (d5_count),
        .pixel_out        (d5_pixel),
        .valid_out        (d5_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        int          due;
        logic [11:0] pix;
        logic        vld;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "_pix"}, 32'(pixel_out), 32'(mon_e.pix));
            check({mon_e.tag, "_vld"}, 32'(valid_out), 32'(mon_e.vld));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        step();
        hcount_in = 11'd1;
    endtask

    task automatic spawn(input int lane, input int speed);
        spawn_valid_in = 1'b1;
        spawn_lane_in  = 2'(lane);
        spawn_speed_in = 3'(speed);
        step();
        spawn_valid_in = 1'b0;
    endtask

    task automatic hit(input int lane);
        hit_valid_in = 1'b1;
        hit_lane_in  = 2'(lane);
        step();
        hit_valid_in = 1'b0;
    endtask

    task automatic probe(input string tag, input int h, input int v,
                         input logic [11:0] p, input logic vl);
        sb_q.push_back('{tag, cyc + 2, p, vl});
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        step();
        hcount_in = 11'd1;
        vcount_in = 10'd0;
        step();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in         = 1'b1;
        hcount_in      = 11'd1;
        vcount_in      = 10'd0;
        spawn_valid_in = 1'b0;
        spawn_lane_in  = 2'd0;
        spawn_speed_in = 3'd0;
        hit_valid_in   = 1'b0;
        hit_lane_in    = 2'd0;
        s5_valid       = 1'b0;
        s5_lane        = 3'd0;
        h5_lane        = 3'd0;

        // Reset state and single-arrow render
        do_reset();
        check("rst_count", 32'(active_count_out), 0);
        check("rst_pix", 32'(pixel_out), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_pulses", {29'd0, hit_out, miss_out, spawn_drop_out}, 0);
        spawn(1, 4);
        check("spawn1_count", 32'(active_count_out), 1);
        for (int i = 0; i < 3; i++) tick();
        probe("p_384_12", 384, 12, 12'h0F0, 1'b1);
        probe("p_392_12", 392, 12, 12'h000, 1'b0);
        probe("p_391_43", 391, 43, 12'h0F0, 1'b1);
        probe("p_384_44", 384, 44, 12'h000, 1'b0);

        // Pool full and out-of-range lane
        do_reset();
        for (int i = 0; i < 8; i++) spawn(i % 4, 1);
        check("fill_count", 32'(active_count_out), 8);
        spawn(2, 1);
        check("drop_pulse", 32'(spawn_drop_out), 1);
        check("drop_count", 32'(active_count_out), 8);
        step();
        check("drop_single", 32'(spawn_drop_out), 0);
        s5_valid = 1'b1; s5_lane = 3'd5; step();
        check("l5_count", 32'(d5_count), 0);
        check("l5_nodrop", 32'(d5_drop), 0);
        s5_lane = 3'd4; step(); step();
        check("l4_count", 32'(d5_count), 2);
        s5_lane = 3'd5; step();
        check("l5_full_nodrop", 32'(d5_drop), 0);
        s5_lane = 3'd0; step();
        check("l0_full_drop", 32'(d5_drop), 1);
        s5_valid = 1'b0;

        // Hit picks the largest y, even from a higher slot index
        do_reset();
        spawn(0, 4);
        for (int i = 0; i < 25; i++) tick();
        spawn(0, 5);
        for (int i = 0; i < 130; i++) tick();
        hit(2);
        check("hit_wrong_lane", 32'(hit_out), 0);
        check("hit_wrong_cnt", 32'(active_count_out), 2);
        hit(0);
        check("hit_pulse", 32'(hit_out), 1);
        check("hit_count", 32'(active_count_out), 1);
        step();
        check("hit_single", 32'(hit_out), 0);
        probe("hit_gone_670", 256, 670, 12'h000, 1'b0);
        probe("hit_keep_620", 256, 620, 12'hF00, 1'b1);
        probe("hit_keep_652", 256, 652, 12'h000, 1'b0);
        hit(0);
        check("hit_second", 32'(hit_out), 1);
        check("hit_second_cnt", 32'(active_count_out), 0);

        // Misses at the exact retire boundary
        do_reset();
        spawn(0, 5);
        spawn(1, 4);
        spawn(2, 5);
        check("miss_setup_cnt", 32'(active_count_out), 3);
        for (int n = 1; n <= 180; n++) begin
            tick();
            if (n == 143) check("miss_143", 32'(miss_out), 0);
            if (n == 144) begin
                check("miss_144", 32'(miss_out), 1);
                check("miss_144_cnt", 32'(active_count_out), 1);
            end
            if (n == 145) check("miss_145", 32'(miss_out), 0);
            if (n == 179) begin
                check("miss_179", 32'(miss_out), 0);
                check("miss_179_cnt", 32'(active_count_out), 1);
                probe("miss_716", 384, 716, 12'h0F0, 1'b1);
            end
            if (n == 180) begin
                check("miss_180", 32'(miss_out), 1);
                check("miss_180_cnt", 32'(active_count_out), 0);
            end
        end

        // Spawn, hit and frame tick all in one cycle
        do_reset();
        for (int i = 0; i < 8; i++) spawn((i == 3) ? 2 : 0, 5);
        for (int i = 0; i < 125; i++) tick();
        hcount_in = 11'd0; vcount_in = 10'd0;
        hit_valid_in = 1'b1; hit_lane_in = 2'd2;
        spawn_valid_in = 1'b1; spawn_lane_in = 2'd1; spawn_speed_in = 3'd1;
        step();
        hcount_in = 11'd1; hit_valid_in = 1'b0; spawn_valid_in = 1'b0;
        check("same_drop", 32'(spawn_drop_out), 1);
        check("same_hit", 32'(hit_out), 1);
        check("same_miss", 32'(miss_out), 0);
        check("same_count", 32'(active_count_out), 7);
        spawn(3, 2);
        check("reuse_count", 32'(active_count_out), 8);
        check("reuse_nodrop", 32'(spawn_drop_out), 0);
        probe("adv_629", 256, 629, 12'h000, 1'b0);
        probe("adv_630", 256, 630, 12'hF00, 1'b1);
        probe("reuse_640_0", 640, 0, 12'hFF0, 1'b1);

        // Speed 0 acts as 1, then reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) spawn(0, 0);
        tick();
        probe("spd0_y0", 256, 0, 12'h000, 1'b0);
        probe("spd0_y1", 256, 1, 12'hF00, 1'b1);
        hcount_in = 11'd256; vcount_in = 10'd5;
        step();
        rst_in = 1'b1; hit_valid_in = 1'b1; spawn_valid_in = 1'b1;
        step();
        check("mrst_count", 32'(active_count_out), 0);
        check("mrst_pix", 32'(pixel_out), 0);
        check("mrst_valid", 32'(valid_out), 0);
        check("mrst_pulses", {29'd0, hit_out, miss_out, spawn_drop_out}, 0);
        rst_in = 1'b0; hit_valid_in = 1'b0; spawn_valid_in = 1'b0;
        hcount_in = 11'd1; vcount_in = 10'd0;
        step();
        check("mrst_valid2", 32'(valid_out), 0);
        check("mrst_count2", 32'(active_count_out), 0);

        step(); step(); step();
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arrow_field.md
Name: arrow_field

Overview:
- Multi-arrow sprite engine for the rhythm-game playfield.
- Holds a pool of NUM_SLOTS falling arrows across NUM_LANES lanes, each arrow with its own speed.
- Advances all arrows once per video frame, resolves player hits against a hit window, and retires arrows that fall off-screen as misses.
- Renders the combined arrow layer as a 12-bit pixel stream with fixed pipeline latency, for the video mixer.

Parameters:
- NUM_SLOTS, 8, number of simultaneously active arrows (1..16).
- NUM_LANES, 4, number of lanes; lane index width LW = $clog2(NUM_LANES).
- WIDTH, 8, arrow width in pixels.
- HEIGHT, 32, arrow height in pixels.
- LANE_X0, 256, x of lane 0 left edge.
- LANE_PITCH, 128, x spacing between lanes.
- HIT_Y, 640, nominal y of the arrow top edge at a perfect hit.
- HIT_TOL, 24, hit window half-width in pixels.
- MISS_Y, 720, arrow retires as a miss when its y reaches or exceeds this value.

Ports:
- clk  in  1  pixel clock.
- rst_in  in  1  synchronous active-high reset.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- spawn_valid_in  in  1  request a new arrow this cycle.
- spawn_lane_in  in  LW  lane of the new arrow.
- spawn_speed_in  in  3  pixels per frame; 0 is treated as 1.
- hit_valid_in  in  1  player pressed a lane this cycle.
- hit_lane_in  in  LW  lane pressed.
- spawn_drop_out  out  1  pulse: spawn rejected because the pool is full.
- hit_out  out  1  pulse: hit resolved.
- miss_out  out  1  pulse: one or more arrows retired off-screen.
- active_count_out  out  $clog2(NUM_SLOTS+1)  number of active slots.
- pixel_out  out  12  arrow colour, or 0.
- valid_out  out  1  an arrow covers the delayed pixel.

Behaviour:
- Reset: all slots inactive, y=0; all outputs 0. Reset mid-frame clears all arrows and zeroes the pixel pipeline in the same edge.
- Per-slot state: active, lane (LW bits), speed (3 bits), y (10 bits).
- Frame tick: asserted for exactly one cycle when hcount_in==0 and vcount_in==0.
- Advance on frame tick: every active slot not hit this cycle updates y <= y + speed, computed in 11 bits.
  - If the 11-bit sum is >= MISS_Y, the slot goes inactive instead of updating.
  - miss_out pulses for 1 cycle if any slot retired this way. Multiple misses in one tick give a single pulse.
- Hit resolution, 1 cycle:
  - Candidates are active slots in hit_lane_in with HIT_Y-HIT_TOL <= y <= HIT_Y+HIT_TOL, using the pre-advance y.
  - The candidate with the largest y wins; ties go to the lowest index.
  - The winner goes inactive and hit_out pulses on the next cycle.
  - No candidate means no pulse and no state change.
- Spawn:
  - A spawn takes the lowest-index slot that is inactive at the start of the cycle. Slots freed this cycle are not reusable until the next cycle.
  - New slot: active=1, y=0, lane, speed (0 becomes 1). A spawned slot is not advanced in the cycle it is spawned.
  - spawn_lane_in >= NUM_LANES: the request is ignored with no drop pulse.
  - Pool full: the request is discarded and spawn_drop_out pulses on the next cycle.
- Simultaneous spawn, hit and frame tick in one cycle are all processed, with hit evaluated before advance.
- active_count_out is registered and reflects slot state after the edge.
- Render pipeline, latency 2 cycles; valid_out and pixel_out correspond to (hcount,vcount) sampled 2 cycles earlier.
  - Stage 1: per-slot coverage is registered. Slot covers when active and x_l <= h <= x_l+WIDTH-1 and y <= v <= y+HEIGHT-1, with x_l = LANE_X0 + lane*LANE_PITCH.
  - Stage 2: the lowest covering slot index wins, and its lane colour is registered.
  - Lane colours by lane[1:0]: 0=12'hF00, 1=12'h0F0, 2=12'h00F, 3=12'hFF0.
  - No coverage gives pixel_out=0 and valid_out=0.
- Coordinate compares use 11-bit arithmetic throughout, with no wrap.

Test Plan:
- Reset, then spawn lane 1 speed 4 -> active_count=1. After 3 frame ticks y=12. Pixel at (384,12) appears 2 cycles later with pixel_out=0x0F0, valid_out=1. Pixel at (392,12) gives valid_out=0.
- Fill 8 slots, then a 9th spawn -> spawn_drop_out pulses once and active_count stays 8. A spawn with lane 5 (NUM_LANES=4) -> ignored with no pulse.
- Two arrows in lane 0 at y=620 and y=650, hit lane 0 -> the y=650 arrow retires, hit_out pulses, the y=620 arrow remains. Hit lane 2 -> no pulse.
- Arrow at y=716 speed 7, frame tick -> retires, miss_out pulses once, active_count decrements. Arrow at y=712 speed 7 -> y=719, still active.
- Same cycle: pool full, frame tick, hit frees slot 3, spawn requested -> spawn dropped, hit_out pulses, others advance. A spawn on the next cycle takes slot 3.
- Assert rst_in mid-frame with 5 active arrows -> next cycle active_count=0, pixel_out=0, valid_out=0, no pulses.
